// File: rtl/elastic_buffered_fork.sv
// Eager fork: one elastic token copied into a per-branch FIFO for every enabled branch; visible one cycle after acceptance.
// Backpressure: stop_input rises only when an enabled branch FIFO is full (registered state, no path from stop_output).

module ebf_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_DEPTH = 1 << PTR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_WIDTH'(1);
    endfunction

    assign full     = (cnt == CNT_WIDTH'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
        end
    end
endmodule

module elastic_buffered_fork #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_NUM    = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_WIDTH-1:0]           input_data,
    input  logic                            valid_input,
    output logic                            stop_input,
    output logic [OUT_NUM*DATA_WIDTH-1:0]   output_data,
    output logic [OUT_NUM-1:0]              valid_output,
    input  logic [OUT_NUM-1:0]              stop_output,
    input  logic [OUT_NUM-1:0]              available_output,
    output logic [OUT_NUM*CNT_WIDTH-1:0]    occupancy
);
    logic               accept;
    logic [OUT_NUM-1:0] full_vec;
    logic [OUT_NUM-1:0] empty_vec;
    logic [OUT_NUM-1:0] push_vec;
    logic [OUT_NUM-1:0] pop_vec;

    // A full FIFO on a disabled branch must not stall the producer.
    assign stop_input = |(available_output & full_vec);
    assign accept     = valid_input & ~stop_input;

    for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_branch
        assign push_vec[gi]     = accept & available_output[gi];
        assign pop_vec[gi]      = ~empty_vec[gi] & ~stop_output[gi];
        assign valid_output[gi] = ~empty_vec[gi];

        ebf_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push_vec[gi]),
            .push_data (input_data),
            .pop       (pop_vec[gi]),
            .pop_data  (output_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .full      (full_vec[gi]),
            .empty     (empty_vec[gi]),
            .count     (occupancy[gi*CNT_WIDTH +: CNT_WIDTH])
        );
    end
endmodule

// File: tb/tb_elastic_buffered_fork.sv
// Bench for elastic_buffered_fork: a DEPTH=2 four-branch instance checked by a per-branch scoreboard,
// plus a DEPTH=1 two-branch instance for the half-rate throughput case.

module tb_elastic_buffered_fork;
    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int D   = 2;
    localparam int CW  = $clog2(D + 1);
    localparam int N1  = 2;
    localparam int D1  = 1;
    localparam int CW1 = $clog2(D1 + 1);

    logic              clk;
    logic              reset_n;
    logic [DW-1:0]     input_data;
    logic              valid_input;
    logic              stop_input;
    logic [N*DW-1:0]   output_data;
    logic [N-1:0]      valid_output;
    logic [N-1:0]      stop_output;
    logic [N-1:0]      available_output;
    logic [N*CW-1:0]   occupancy;

    logic [DW-1:0]     d1_input_data;
    logic              d1_valid_input;
    logic              d1_stop_input;
    logic [N1*DW-1:0]  d1_output_data;
    logic [N1-1:0]     d1_valid_output;
    logic [N1-1:0]     d1_stop_output;
    logic [N1-1:0]     d1_available_output;
    logic [N1*CW1-1:0] d1_occupancy;

    int vectors = 0;
    int errors  = 0;
    logic [DW-1:0] exp_q [N][$];
    logic [DW-1:0] d1_q [$];

    elastic_buffered_fork #(.DATA_WIDTH(DW), .OUT_NUM(N), .DEPTH(D)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .input_data       (input_data),
        .valid_input      (valid_input),
        .stop_input       (stop_input),
        .output_data      (output_data),
        .valid_output     (valid_output),
        .stop_output      (stop_output),
        .available_output (available_output),
        .occupancy        (occupancy)
    );

    elastic_buffered_fork #(.DATA_WIDTH(DW), .OUT_NUM(N1), .DEPTH(D1)) u_dut_d1 (
        .clk              (clk),
        .reset_n          (reset_n),
        .input_data       (d1_input_data),
        .valid_input      (d1_valid_input),
        .stop_input       (d1_stop_input),
        .output_data      (d1_output_data),
        .valid_output     (d1_valid_output),
        .stop_output      (d1_stop_output),
        .available_output (d1_available_output),
        .occupancy        (d1_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each token leaving a branch, then record tokens entering.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid_output[i] && !stop_output[i]) begin
                    vectors++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL sb_branch%0d: got token %h, expected no token", i, output_data[i*DW +: DW]);
                    end else begin
                        logic [DW-1:0] exp;
                        exp = exp_q[i].pop_front();
                        if (output_data[i*DW +: DW] !== exp) begin
                            errors++;
                            $display("FAIL sb_branch%0d: got %h, expected %h", i, output_data[i*DW +: DW], exp);
                        end
                    end
                end
            end
            if (valid_input && !stop_input) begin
                for (int i = 0; i < N; i++) begin
                    if (available_output[i]) exp_q[i].push_back(input_data);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b1;
        input_data = '0; valid_input = 1'b0; stop_output = '0; available_output = '1;
        d1_input_data = '0; d1_valid_input = 1'b0; d1_stop_output = '0; d1_available_output = '1;
        #2 reset_n = 1'b0;
        #6;
        vectors++; if (valid_output !== '0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_output); end
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b, expected 0", stop_input); end
        vectors++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ: got %h, expected 0", occupancy); end
        vectors++; if (output_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 0", output_data); end
        vectors++; if (d1_valid_output !== '0) begin errors++; $display("FAIL reset_d1_valid: got %b, expected 0", d1_valid_output); end
        vectors++; if (d1_occupancy !== '0) begin errors++; $display("FAIL reset_d1_occ: got %h, expected 0", d1_occupancy); end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] toks [3];
        toks[0] = 8'h11; toks[1] = 8'h22; toks[2] = 8'h33;
        available_output = 4'b1111; stop_output = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin valid_input = 1'b1; input_data = toks[k]; end
            else valid_input = 1'b0;
            @(negedge clk);
            if (k < 3) begin
                vectors++;
                if (stop_input !== 1'b0) begin errors++; $display("FAIL stream_stop%0d: got %b, expected 0", k, stop_input); end
            end
            if (k >= 1) begin
                vectors++;
                if (valid_output !== 4'b1111) begin errors++; $display("FAIL stream_valid%0d: got %b, expected 1111", k, valid_output); end
                for (int i = 0; i < N; i++) begin
                    vectors++;
                    if (output_data[i*DW +: DW] !== toks[k-1]) begin
                        errors++; $display("FAIL stream_data%0d_b%0d: got %h, expected %h", k, i, output_data[i*DW +: DW], toks[k-1]);
                    end
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (valid_output !== '0) begin errors++; $display("FAIL stream_end_valid: got %b, expected 0", valid_output); end
        vectors++; if (occupancy !== '0) begin errors++; $display("FAIL stream_end_occ: got %h, expected 0", occupancy); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (exp_q[i].size() != 0) begin errors++; $display("FAIL stream_left_b%0d: got %0d pending, expected 0", i, exp_q[i].size()); end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int budget = 0;
        available_output = 4'b1111; stop_output = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 valid_input = 1'b1; input_data = 8'hA0 + DW'(sent);
            @(negedge clk);
            if (!stop_input) sent++;
        end
        vectors++; if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d, expected 2", sent); end
        vectors++; if (stop_input !== 1'b1) begin errors++; $display("FAIL bp_stop: got %b, expected 1", stop_input); end
        vectors++; if (occupancy[2*CW +: CW] !== CW'(2)) begin errors++; $display("FAIL bp_occ2: got %0d, expected 2", occupancy[2*CW +: CW]); end
        vectors++; if (valid_output !== 4'b0100) begin errors++; $display("FAIL bp_valid: got %b, expected 0100", valid_output); end
        vectors++; if (output_data[2*DW +: DW] !== 8'hA0) begin errors++; $display("FAIL bp_head2: got %h, expected a0", output_data[2*DW +: DW]); end
        @(posedge clk); #1 stop_output = '0;
        while (sent < 5 && budget < 20) begin
            @(posedge clk); #1 valid_input = 1'b1; input_data = 8'hA0 + DW'(sent);
            @(negedge clk);
            if (!stop_input) sent++;
            budget++;
        end
        vectors++; if (sent != 5) begin errors++; $display("FAIL bp_timeout: got %0d accepted, expected 5", sent); end
        @(posedge clk); #1 valid_input = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (occupancy !== '0) begin errors++; $display("FAIL bp_end_occ: got %h, expected 0", occupancy); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (exp_q[i].size() != 0) begin errors++; $display("FAIL bp_left_b%0d: got %0d pending, expected 0", i, exp_q[i].size()); end
        end
    endtask

    task automatic test_enable_mask();
        stop_output = '0;
        @(posedge clk); #1 available_output = 4'b0101; valid_input = 1'b1; input_data = 8'h5A;
        @(negedge clk);
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL mask_stop: got %b, expected 0", stop_input); end
        @(posedge clk); #1 available_output = 4'b0000; input_data = 8'h77;
        @(negedge clk);
        vectors++; if (valid_output !== 4'b0101) begin errors++; $display("FAIL mask_valid: got %b, expected 0101", valid_output); end
        vectors++; if (output_data[0 +: DW] !== 8'h5A) begin errors++; $display("FAIL mask_b0: got %h, expected 5a", output_data[0 +: DW]); end
        vectors++; if (output_data[2*DW +: DW] !== 8'h5A) begin errors++; $display("FAIL mask_b2: got %h, expected 5a", output_data[2*DW +: DW]); end
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL mask_none_stop: got %b, expected 0", stop_input); end
        @(posedge clk); #1 valid_input = 1'b0;
        @(negedge clk);
        vectors++; if (valid_output !== '0) begin errors++; $display("FAIL mask_none_valid: got %b, expected 0", valid_output); end
        vectors++; if (occupancy !== '0) begin errors++; $display("FAIL mask_none_occ: got %h, expected 0", occupancy); end
        available_output = 4'b1111;
    endtask

    task automatic test_disable_full();
        available_output = 4'b1111; stop_output = 4'b0010;
        @(posedge clk); #1 valid_input = 1'b1; input_data = 8'hB1;
        @(posedge clk); #1 input_data = 8'hB2;
        @(posedge clk); #1 valid_input = 1'b0;
        @(negedge clk);
        vectors++; if (stop_input !== 1'b1) begin errors++; $display("FAIL dis_stop_full: got %b, expected 1", stop_input); end
        vectors++; if (occupancy[CW +: CW] !== CW'(2)) begin errors++; $display("FAIL dis_occ_full: got %0d, expected 2", occupancy[CW +: CW]); end
        @(posedge clk); #1 available_output = 4'b1101;
        @(negedge clk);
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL dis_stop_off: got %b, expected 0", stop_input); end
        vectors++; if (valid_output !== 4'b0010) begin errors++; $display("FAIL dis_valid: got %b, expected 0010", valid_output); end
        @(posedge clk); #1 stop_output = '0;
        @(negedge clk);
        vectors++; if (output_data[DW +: DW] !== 8'hB1) begin errors++; $display("FAIL dis_head1: got %h, expected b1", output_data[DW +: DW]); end
        @(negedge clk);
        vectors++; if (output_data[DW +: DW] !== 8'hB2) begin errors++; $display("FAIL dis_head2: got %h, expected b2", output_data[DW +: DW]); end
        vectors++; if (occupancy[CW +: CW] !== CW'(1)) begin errors++; $display("FAIL dis_occ_one: got %0d, expected 1", occupancy[CW +: CW]); end
        @(negedge clk);
        vectors++; if (valid_output !== '0) begin errors++; $display("FAIL dis_drained: got %b, expected 0", valid_output); end
        available_output = 4'b1111;
    endtask

    task automatic test_depth1_rate();
        int acc = 0;
        d1_available_output = 2'b11; d1_stop_output = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            d1_valid_input = (c < 8); d1_input_data = 8'hD0 + DW'(acc);
            @(negedge clk);
            if (d1_valid_output[0]) begin
                vectors++;
                if (d1_q.size() == 0) begin
                    errors++; $display("FAIL d1_extra: got token %h, expected none", d1_output_data[0 +: DW]);
                end else begin
                    logic [DW-1:0] exp;
                    exp = d1_q.pop_front();
                    for (int i = 0; i < N1; i++) begin
                        if (d1_output_data[i*DW +: DW] !== exp) begin
                            errors++; $display("FAIL d1_data_b%0d: got %h, expected %h", i, d1_output_data[i*DW +: DW], exp);
                        end
                    end
                end
            end
            if (c < 8) begin
                logic exp_stop;
                exp_stop = (c % 2) == 1;
                vectors++;
                if (d1_stop_input !== exp_stop) begin errors++; $display("FAIL d1_stop_c%0d: got %b, expected %b", c, d1_stop_input, exp_stop); end
                if (!d1_stop_input) begin d1_q.push_back(d1_input_data); acc++; end
            end
        end
        vectors++; if (acc != 4) begin errors++; $display("FAIL d1_count: got %0d, expected 4", acc); end
        vectors++; if (d1_q.size() != 0) begin errors++; $display("FAIL d1_left: got %0d pending, expected 0", d1_q.size()); end
        d1_valid_input = 1'b0;
    endtask

    task automatic test_reset_mid();
        available_output = 4'b1111; stop_output = 4'b1111;
        @(posedge clk); #1 valid_input = 1'b1; input_data = 8'hC1;
        @(posedge clk); #1 input_data = 8'hC2;
        @(posedge clk); #1 valid_input = 1'b0;
        @(negedge clk);
        vectors++; if (occupancy[0 +: CW] !== CW'(2)) begin errors++; $display("FAIL rst_pre_occ: got %0d, expected 2", occupancy[0 +: CW]); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (valid_output !== '0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", valid_output); end
        vectors++; if (occupancy !== '0) begin errors++; $display("FAIL rst_occ: got %h, expected 0", occupancy); end
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL rst_stop: got %b, expected 0", stop_input); end
        vectors++; if (output_data !== '0) begin errors++; $display("FAIL rst_data: got %h, expected 0", output_data); end
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1; stop_output = '0; valid_input = 1'b1; input_data = 8'h3C;
        @(negedge clk);
        vectors++; if (stop_input !== 1'b0) begin errors++; $display("FAIL rst_after_stop: got %b, expected 0", stop_input); end
        @(posedge clk); #1 valid_input = 1'b0;
        @(negedge clk);
        vectors++; if (valid_output !== 4'b1111) begin errors++; $display("FAIL rst_after_valid: got %b, expected 1111", valid_output); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (output_data[i*DW +: DW] !== 8'h3C) begin errors++; $display("FAIL rst_after_b%0d: got %h, expected 3c", i, output_data[i*DW +: DW]); end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (exp_q[i].size() != 0) begin errors++; $display("FAIL rst_left_b%0d: got %0d pending, expected 0", i, exp_q[i].size()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_enable_mask();
        test_disable_full();
        test_depth1_rate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
